// File: rtl/resampler_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resampler_out_fifo
// Description : Elastic output buffer behind the multi-stream polyphase
//               resampling filter. Accepts round-robin samples over a req/ack
//               handshake, tags each one with its stream index and a
//               last-of-round flag, stores them in a circular buffer and
//               presents them to the sink through a registered output stage.
//
// Ports       : clk         sole clock, posedge
//               rst         synchronous active-high reset
//               req_in      filter has a valid sample
//               ack_in      block can accept a sample (registered)
//               data_in     sample from filter
//               req_out     output register holds a valid sample
//               ack_out     sink accepts the sample
//               data_out    buffered sample
//               stream_out  stream index of data_out
//               last_out    data_out belongs to stream NR_STREAMS-1
//               level       occupied storage entries (output register excluded)
//
// Revision    : 1.0 - initial release
// ============================================================================
module resampler_out_fifo #(
    parameter int DWIDTH         = 16,
    parameter int DEPTH          = 16,
    parameter int DEPTH_LOG      = 4,
    parameter int NR_STREAMS     = 1024,
    parameter int NR_STREAMS_LOG = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_in,
    output logic                      ack_in,
    input  logic [DWIDTH-1:0]         data_in,
    output logic                      req_out,
    input  logic                      ack_out,
    output logic [DWIDTH-1:0]         data_out,
    output logic [NR_STREAMS_LOG-1:0] stream_out,
    output logic                      last_out,
    output logic [DEPTH_LOG:0]        level
);

    // Storage entry layout: {last, stream, data}
    localparam int                      c_ENTRY_W     = DWIDTH + NR_STREAMS_LOG + 1;
    localparam logic [DEPTH_LOG:0]      c_LEVEL_FULL  = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [NR_STREAMS_LOG-1:0] c_LAST_STREAM = NR_STREAMS_LOG'(NR_STREAMS - 1);

    logic [c_ENTRY_W-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG-1:0]      r_wr_ptr;
    logic [DEPTH_LOG-1:0]      r_rd_ptr;
    logic [NR_STREAMS_LOG-1:0] r_stream;
    logic [DEPTH_LOG:0]        r_level;
    logic                      r_ack_in;
    logic                      r_req_out;
    logic [DWIDTH-1:0]         r_data_out;
    logic [NR_STREAMS_LOG-1:0] r_stream_out;
    logic                      r_last_out;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_load;
    logic [DEPTH_LOG:0]        w_level_next;
    logic [c_ENTRY_W-1:0]      w_head;
    logic                      w_last_tag;

    assign w_push     = req_in && r_ack_in;
    assign w_pop      = r_req_out && ack_out;
    // The output register refills only from words already in storage; a word
    // written this cycle is not visible until the next edge (no bypass).
    assign w_load     = (!r_req_out || w_pop) && (r_level != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_last_tag = (r_stream == c_LAST_STREAM);

    always_comb begin
        w_level_next = r_level + {{DEPTH_LOG{1'b0}}, w_push}
                               - {{DEPTH_LOG{1'b0}}, w_load};
    end

    // Storage array: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= {w_last_tag, r_stream, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_stream     <= '0;
            r_level      <= '0;
            r_ack_in     <= 1'b0;
            r_req_out    <= 1'b0;
            r_data_out   <= '0;
            r_stream_out <= '0;
            r_last_out   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG'(1);
                r_stream <= r_stream + NR_STREAMS_LOG'(1);
            end

            if (w_load) begin
                r_rd_ptr     <= r_rd_ptr + DEPTH_LOG'(1);
                r_req_out    <= 1'b1;
                r_data_out   <= w_head[DWIDTH-1:0];
                r_stream_out <= w_head[DWIDTH +: NR_STREAMS_LOG];
                r_last_out   <= w_head[c_ENTRY_W-1];
            end else if (w_pop) begin
                r_req_out <= 1'b0;
            end

            r_level <= w_level_next;
            // ack_in is registered from the post-update level, so it drops the
            // cycle storage becomes full and an overrun can never be accepted.
            r_ack_in <= (w_level_next < c_LEVEL_FULL);
        end
    end

    assign ack_in     = r_ack_in;
    assign req_out    = r_req_out;
    assign data_out   = r_data_out;
    assign stream_out = r_stream_out;
    assign last_out   = r_last_out;
    assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_resampler_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_resampler_out_fifo
// Description : Self-checking bench for resampler_out_fifo (DEPTH=16,
//               NR_STREAMS=4). A word-level queue model tracks every accepted
//               sample and its expected tag; directed sequences cover reset,
//               latency, fill, stream wrap, backpressure and mid-stream reset,
//               followed by a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resampler_out_fifo;

    localparam int DW   = 16;
    localparam int DEP  = 16;
    localparam int NS   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_in;
    logic          ack_in;
    logic [DW-1:0] data_in;
    logic          req_out;
    logic          ack_out;
    logic [DW-1:0] data_out;
    logic [1:0]    stream_out;
    logic          last_out;
    logic [4:0]    level;

    resampler_out_fifo #(
        .DWIDTH         (DW),
        .DEPTH          (DEP),
        .DEPTH_LOG      (4),
        .NR_STREAMS     (NS),
        .NR_STREAMS_LOG (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .ack_in     (ack_in),
        .data_in    (data_in),
        .req_out    (req_out),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .stream_out (stream_out),
        .last_out   (last_out),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: queue of words held in the block ----
    // Entry layout {last, stream[1:0], data[15:0]}
    logic [18:0] q[$];
    int          cnt   = 0;
    logic        rst_q = 1'b1;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        rst_q <= rst;
        armed <= 1'b1;
    end

    // At the negedge all inputs and outputs are stable for the coming edge.
    always @(negedge clk) begin
        if (armed) begin
            if (rst_q) begin
                chk("rst_ack_in",  {31'd0, ack_in},  32'd0);
                chk("rst_req_out", {31'd0, req_out}, 32'd0);
                chk("rst_level",   {27'd0, level},   32'd0);
                chk("rst_data",    {16'd0, data_out}, 32'd0);
                chk("rst_tag",     {29'd0, last_out, stream_out}, 32'd0);
            end else begin
                chk("level_acct", {27'd0, level}, 32'(q.size() - int'(req_out)));
                chk("ack_in_lvl", {31'd0, ack_in}, {31'd0, (level < 5'd16)});
                if (req_out) begin
                    if (q.size() == 0) begin
                        chk("phantom_word", {31'd0, req_out}, 32'd0);
                    end else begin
                        chk("out_data",   {16'd0, data_out},   {16'd0, q[0][15:0]});
                        chk("out_stream", {30'd0, stream_out}, {30'd0, q[0][17:16]});
                        chk("out_last",   {31'd0, last_out},   {31'd0, q[0][18]});
                    end
                end
            end
            // Advance the model with the transfers the next edge will perform.
            if (rst) begin
                q.delete();
                cnt = 0;
            end else begin
                if (req_out && ack_out && q.size() > 0) void'(q.pop_front());
                if (req_in && ack_in) begin
                    q.push_back({(cnt == NS - 1), 2'(cnt), data_in});
                    cnt = (cnt + 1) % NS;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int n_acc;
    int got;
    int pushed;
    int ack_pct;
    bit acc;

    initial begin
        rst     = 1'b1;
        req_in  = 1'b0;
        ack_out = 1'b0;
        data_in = '0;

        // Reset held for three edges, then released.
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("post_rst_ack_in",  {31'd0, ack_in},  32'd1);
        chk("post_rst_req_out", {31'd0, req_out}, 32'd0);

        // Single word: visible two edges after the transfer edge.
        ack_out = 1'b1;
        req_in  = 1'b1;
        data_in = 16'h1234;
        step();
        req_in = 1'b0;
        chk("single_lat0", {31'd0, req_out}, 32'd0);
        step();
        chk("single_req",    {31'd0, req_out},    32'd1);
        chk("single_data",   {16'd0, data_out},   32'h1234);
        chk("single_stream", {30'd0, stream_out}, 32'd0);
        chk("single_last",   {31'd0, last_out},   32'd0);
        step();
        chk("single_gone", {31'd0, req_out}, 32'd0);

        // Fill with the sink stalled: capacity is DEPTH+1 words.
        ack_out = 1'b0;
        req_in  = 1'b1;
        n_acc   = 0;
        data_in = '0;
        for (int i = 0; i < 25; i++) begin
            acc = ack_in;
            step();
            if (acc) n_acc++;
            data_in = 16'(n_acc);
        end
        req_in = 1'b0;
        chk("fill_count",  32'(n_acc), 32'd17);
        chk("fill_ack_in", {31'd0, ack_in},  32'd0);
        chk("fill_level",  {27'd0, level},   32'd16);
        chk("fill_hold",   {16'd0, data_out}, 32'd0);
        ack_out = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("drain_req",  {31'd0, req_out},  32'd1);
            chk("drain_data", {16'd0, data_out}, 32'(i));
            step();
        end
        chk("drain_empty", {31'd0, req_out}, 32'd0);

        // Mid-stream reset with five words in storage.
        ack_out = 1'b0;
        req_in  = 1'b1;
        n_acc   = 0;
        for (int i = 0; i < 30 && n_acc < 6; i++) begin
            data_in = 16'($urandom);
            acc = ack_in;
            step();
            if (acc) n_acc++;
        end
        req_in = 1'b0;
        step();
        chk("mid_level5", {27'd0, level},   32'd5);
        chk("mid_req",    {31'd0, req_out}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_req",   {31'd0, req_out}, 32'd0);
        chk("mid_rst_level", {27'd0, level},   32'd0);

        // Stream wrap: nine words straight after reset.
        ack_out = 1'b1;
        req_in  = 1'b1;
        pushed  = 0;
        got     = 0;
        for (int i = 0; i < 60 && got < 9; i++) begin
            if (req_out && ack_out) begin
                chk("wrap_stream", {30'd0, stream_out}, 32'(got % NS));
                chk("wrap_last",   {31'd0, last_out},   {31'd0, ((got % NS) == NS - 1)});
                got++;
            end
            acc = ack_in && req_in;
            step();
            if (acc) pushed++;
            if (pushed >= 9) req_in = 1'b0;
            data_in = 16'($urandom);
        end
        chk("wrap_count", 32'(got), 32'd9);

        // Backpressure toggle: sink accepts every other cycle.
        req_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ack_out = i[0];
            data_in = 16'($urandom);
            chk("bp_ack_in", {31'd0, ack_in}, 32'd1);
            step();
        end
        req_in  = 1'b0;
        ack_out = 1'b1;
        repeat (25) step();
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Randomized traffic with varying sink duty and rare resets.
        ack_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) ack_pct = $urandom_range(0, 100);
            req_in  = ($urandom_range(0, 9) < 7);
            ack_out = ($urandom_range(0, 99) < ack_pct);
            data_in = 16'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
            step();
        end
        rst     = 1'b0;
        req_in  = 1'b0;
        ack_out = 1'b1;
        repeat (40) step();
        chk("final_drained", 32'(q.size()), 32'd0);
        chk("final_req_out", {31'd0, req_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resampler_out_fifo.md
Name: resampler_out_fifo

Overview:
- Elastic output buffer directly downstream of the multi-stream polyphase resampling filter.
- Accepts the filter's round-robin output samples over its req/ack handshake and stores them in a circular buffer.
- Tags each sample with its stream index and a last-of-round flag.
- Presents tagged samples to the sink over a second req/ack handshake, decoupling the filter from sink stalls.

Parameters:
- DWIDTH, 16, sample width in bits.
- DEPTH, 16, storage entries; must be a power of 2.
- DEPTH_LOG, 4, log2(DEPTH).
- NR_STREAMS, 1024, streams interleaved by the filter; must be a power of 2.
- NR_STREAMS_LOG, 10, log2(NR_STREAMS).

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  1  upstream (filter) has a valid sample.
- ack_in  output  1  block can accept a sample.
- data_in  input  DWIDTH  sample from filter.
- req_out  output  1  output register holds a valid sample.
- ack_out  input  1  sink accepts the sample.
- data_out  output  DWIDTH  buffered sample.
- stream_out  output  NR_STREAMS_LOG  stream index of data_out.
- last_out  output  1  data_out belongs to stream NR_STREAMS-1.
- level  output  DEPTH_LOG+1  occupied storage entries, excluding the output register.

Behaviour:
- Clocking and reset: one clock, posedge only. Reset is synchronous and active-high (rst sampled at posedge clk).
- Reset values:
  - Outputs: ack_in=0, req_out=0, data_out=0, stream_out=0, last_out=0, level=0.
  - Internal: write pointer, read pointer and write-stream counter = 0.
  - Reset mid-operation discards all stored and output-register contents and restarts stream tagging at 0. Memory contents are don't-care.
- Transfers:
  - Input transfer occurs at a posedge where req_in && ack_in.
  - Output transfer occurs at a posedge where req_out && ack_out.
  - Neither side may stall or cancel a transfer the other side has already acknowledged.
- Tagging:
  - Each accepted word is stored with tag {stream, last}.
  - stream = write-stream counter; last = (counter == NR_STREAMS-1).
  - Counter increments by 1 mod NR_STREAMS per accepted word. Wrap from NR_STREAMS-1 to 0 is natural.
- Storage: circular buffer, DEPTH entries of DWIDTH+NR_STREAMS_LOG+1 bits; pointers wrap mod DEPTH.
- Output register:
  - Loads from storage head when it is empty, or is being emptied this cycle by an output transfer, and storage is non-empty.
  - req_out is set when the register loads and cleared when emptied with nothing to load.
  - data_out, stream_out and last_out hold stable while req_out=1 and ack_out=0.
- Latency:
  - A word accepted at edge k, into an empty block, is stored at edge k and loaded into the output register at edge k+1.
  - req_out therefore rises after edge k+1.
  - No storage bypass.
- level:
  - Counts storage entries only.
  - +1 on an input transfer; -1 on a register load from storage; unchanged when both occur in the same cycle.
- ack_in:
  - Registered; next value = (level_next < DEPTH) and not in reset.
  - Rises the cycle after rst deasserts.
  - Drops the cycle after the storage fills, so overrun is impossible.
  - Total capacity = DEPTH+1 words (storage plus output register).
- Throughput: with req_in=1 and ack_out=1 held, one word per cycle in steady state; level stays constant.
- Full boundary: when full, an output transfer frees one entry; ack_in re-rises on the next edge.
- Empty boundary: when empty, req_out=0 and level=0.
- Simultaneous write to an empty buffer and output transfer: the new word is stored only; the register empties and reloads on the following edge.

Test Plan:
- Reset: hold rst 3 cycles, then release -> all outputs 0 during reset; ack_in=1 from the first edge after release; req_out stays 0.
- Single word: req_in=1 with data_in=0x1234 for one transfer, ack_out=1 -> req_out=1 two edges after the transfer edge; data_out=0x1234, stream_out=0, last_out=0; req_out=0 after the following edge.
- Fill (DEPTH=16): ack_out=0, req_in=1 with data 0,1,2,... -> exactly 17 words accepted; ack_in=0 afterward; level=16; data_out=0 held. Raise ack_out -> words 0..16 emerge in order, one per cycle.
- Stream wrap (NR_STREAMS=4): push 9 words -> stream_out sequence 0,1,2,3,0,1,2,3,0; last_out=1 only on the 4th and 8th words.
- Backpressure toggle: req_in=1 constant, ack_out alternating 1/0 -> no word lost or duplicated; output order matches input order; ack_in never deasserts.
- Reset mid-stream: rst asserted for one cycle with level=5 -> next cycle req_out=0 and level=0; first subsequent word has stream_out=0.
